pipe_stage_elastic: RTL
=======================

Name: pipe_stage_elastic

Overview:
- Parametrised successor to the fixed inter-stage pipeline registers (ID/EX, EX/MEM, MEM/WB).
- Carries a control field and a data field through DEPTH register slots.
- Each slot has a valid bit and a valid/ready handshake, so stall back-pressure and bubble-collapsing are handled locally.
- A synchronous flush squashes in-flight entries, e.g. on branch redirect. Control bits of any non-valid slot read as zero, so a squashed or bubble entry can never assert RegWrite/MemWrite downstream.

Parameters:
- DATA_W, 96, width of data payload (e.g. ALU result, Dout, PC concatenated).
- CTRL_W, 12, width of control payload (RegWrite, MemtoReg, WriteReg, load_option, ...); zeroed whenever the slot is invalid.
- DEPTH, 1, number of register slots; legal 1..8.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  synchronous squash of all slots and of the incoming beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  slot 0 can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control field.
- in_data  in  DATA_W  upstream data field.
- out_valid  out  1  last slot holds a valid beat.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  last-slot control; forced to 0 when out_valid=0.
- out_data  out  DATA_W  last-slot data; undefined-but-stable when out_valid=0.
- occupancy  out  CNT_W  number of valid slots.

Behaviour:
- Reset (reset=0 at posedge): all valid bits cleared, all ctrl and data registers set to 0. Outputs read out_valid=0, out_ctrl=0, out_data=0, occupancy=0. Reset has priority over flush and all transfers.
- Slot k ready: rdy[k] = !v[k] | rdy[k+1]; rdy[DEPTH] = out_ready. This is combinational and has no registered ready. in_ready = rdy[0].
- Slot k loads from slot k-1 (slot 0 loads from in_*) when rdy[k]=1.
  - The new v[k] is the upstream valid.
  - ctrl is loaded as upstream ctrl AND upstream valid, so bubbles carry ctrl=0.
  - Data loads whenever rdy[k]=1.
- Slot k holds all fields when rdy[k]=0.
- Latency: DEPTH cycles from in_valid&in_ready to out_valid with out_ready held 1. Throughput is 1 beat/cycle.
- Bubble collapse: with out_ready=0, upstream slots keep filling until every slot is valid. Only then does in_ready drop.
- Flush (reset=1, flush=1 at posedge):
  - All v cleared and all ctrl cleared; data regs hold.
  - The incoming beat is discarded even if in_valid&in_ready.
  - A beat with out_valid&out_ready in the same cycle counts as consumed downstream; the flush does not cancel it.
  - in_ready remains the normal combinational value.
- occupancy is the registered count of valid slots, updated each cycle with +1 on accept, -1 on emit, and 0 on flush or reset. Simultaneous accept and emit leave it unchanged.
- Invariants:
  - occupancy ≤ DEPTH.
  - out_ctrl == 0 whenever out_valid == 0.
  - No beat is duplicated or dropped except by flush.
  - Order is preserved.
- DEPTH=1 reduces to a single register with valid, stall and flush; this is the drop-in replacement for existing fixed stage registers.

Decomposition:
- Shared package pipe_pkg: MEM_WB_CTRL_W/EX_MEM_CTRL_W constants, and packed ctrl field bit offsets (REGWRITE_BIT, MEMTOREG_BIT, WRITEREG_LSB, LOADOPT_LSB, PCSRC_LSB).
- One sub-module, pipe_slot: a single valid/ctrl/data slot with the load/hold/flush logic. It is instantiated DEPTH times in a generate loop. The top level holds the ready chain and the occupancy counter.

Test Plan:
- Reset during activity: DEPTH=3, fill 3 beats with out_ready=0, then drive reset=0 for 1 cycle → next cycle occupancy=0, out_valid=0, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: DEPTH=3, out_ready=1, beats data=1,2,3 ctrl=0x001 on consecutive cycles → out_data 1,2,3 appear on cycles 3,4,5 with out_valid=1; occupancy stays 3 in steady state.
- Back-pressure/bubble collapse: DEPTH=3, send beat A, one idle cycle, then beat B, with out_ready=0 → after 2 more cycles occupancy=2 with slots packed at the output end, in_ready=1. Send C → occupancy=3, in_ready=0. Raise out_ready → A,B,C emitted in order, no gaps.
- Flush with concurrent traffic: DEPTH=2 full (A,B), out_ready=1, in_valid=1 (C), flush=1 for one cycle → A counted as emitted that cycle. Next cycle out_valid=0, out_ctrl=0, occupancy=0; C never appears.
- Control gating: DEPTH=1, in_valid=0 with in_ctrl=0xFFF for 5 cycles, out_ready=1 → out_ctrl=0 every cycle.
- DEPTH=1 equivalence: random in_valid/in_ready/out_ready/flush for 1000 cycles versus a scoreboard queue model → identical out_valid/out_ctrl/out_data sequence and occupancy.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-register definitions: control-field widths and
// bit positions of the packed control word carried between stages.
package pipe_pkg;

    // Control word widths for the stage registers being replaced.
    localparam int MEM_WB_CTRL_W = 10;
    localparam int EX_MEM_CTRL_W = 12;

    // Packed control field layout (LSB first).
    localparam int REGWRITE_BIT = 0;
    localparam int MEMTOREG_BIT = 1;
    localparam int WRITEREG_LSB = 2;
    localparam int WRITEREG_W   = 5;
    localparam int LOADOPT_LSB  = 7;
    localparam int LOADOPT_W    = 3;
    localparam int PCSRC_LSB    = 10;
    localparam int PCSRC_W      = 2;

    // Upper bound on the number of slots in one elastic stage.
    localparam int MAX_DEPTH = 8;

endpackage

// File: rtl/pipe_slot.sv
// One elastic pipeline slot: valid bit, control and data registers.
// Ports: clock, reset (sync, active-low), flush, load (slot ready),
//   up_valid/up_ctrl/up_data (from previous slot or upstream),
//   valid/ctrl/data (slot contents; ctrl reads zero when invalid).
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DATA_W = 96
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              load,
    input  logic              up_valid,
    input  logic [CTRL_W-1:0] up_ctrl,
    input  logic [DATA_W-1:0] up_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    logic              v_q;
    logic [CTRL_W-1:0] c_q;
    logic [DATA_W-1:0] d_q;

    // Data holds on flush; only valid and control are squashed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            v_q <= 1'b0;
            c_q <= '0;
            d_q <= '0;
        end else if (flush) begin
            v_q <= 1'b0;
            c_q <= '0;
        end else if (load) begin
            v_q <= up_valid;
            c_q <= up_ctrl & {CTRL_W{up_valid}};
            d_q <= up_data;
        end
    end

    assign valid = v_q;
    assign ctrl  = c_q & {CTRL_W{v_q}};
    assign data  = d_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: DEPTH valid/ready slots with
// bubble collapse, synchronous flush and an occupancy counter.
// Ports: clock, reset (sync, active-low), flush,
//   in_valid/in_ready/in_ctrl/in_data (upstream handshake),
//   out_valid/out_ready/out_ctrl/out_data (downstream handshake),
//   occupancy (registered count of valid slots).
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int DEPTH  = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  up_v;
    logic [CTRL_W-1:0] c    [DEPTH];
    logic [DATA_W-1:0] d    [DEPTH];
    logic [CTRL_W-1:0] up_c [DEPTH];
    logic [DATA_W-1:0] up_d [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        // Unrolled form of rdy[k] = !v[k] | rdy[k+1]: a slot can move
        // when any slot at or past it is empty, or the sink accepts.
        assign rdy[k] = out_ready | ~(&v[DEPTH-1:k]);

        if (k == 0) begin : g_head
            assign up_v[k] = in_valid;
            assign up_c[k] = in_ctrl;
            assign up_d[k] = in_data;
        end else begin : g_link
            assign up_v[k] = v[k-1];
            assign up_c[k] = c[k-1];
            assign up_d[k] = d[k-1];
        end

        pipe_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_slot (
            .clock    (clock),
            .reset    (reset),
            .flush    (flush),
            .load     (rdy[k]),
            .up_valid (up_v[k]),
            .up_ctrl  (up_c[k]),
            .up_data  (up_d[k]),
            .valid    (v[k]),
            .ctrl     (c[k]),
            .data     (d[k])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[DEPTH-1];
    assign out_ctrl  = c[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    logic             acc;
    logic             emit;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign acc  = in_valid & in_ready;
    assign emit = out_valid & out_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            case ({acc, emit})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign occupancy = cnt_q;

endmodule
